// File: rtl/pcie_axi_mem_responder_pkg.sv
// rtl/pcie_axi_mem_responder_pkg.sv - shared AXI constants and FSM state types for the memory responder
package pcie_axi_mem_responder_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] INCR   = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

endpackage

// File: rtl/pcie_axi_mem_responder_if.sv
// rtl/pcie_axi_mem_responder_if.sv - AXI4 address, write-data, write-response and read-data channel interfaces
interface AXI4_A_IF #(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 64
);
  logic                  avalid;
  logic                  aready;
  logic [ID_WIDTH-1:0]   aid;
  logic [ADDR_WIDTH-1:0] aaddr;
  logic [7:0]            alen;
  logic [2:0]            asize;
  logic [1:0]            aburst;
  logic [3:0]            acache;
  logic [2:0]            aprot;
  logic [3:0]            aqos;
  logic [3:0]            aregion;

  modport master (output avalid, aid, aaddr, alen, asize, aburst, acache, aprot, aqos, aregion,
                  input  aready);
  modport slave  (input  avalid, aid, aaddr, alen, asize, aburst, acache, aprot, aqos, aregion,
                  output aready);
endinterface

interface AXI4_W_IF #(
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;

  modport master (output wvalid, wdata, wstrb, wlast, input  wready);
  modport slave  (input  wvalid, wdata, wstrb, wlast, output wready);
endinterface

interface AXI4_B_IF #(
  parameter int ID_WIDTH = 6
);
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;

  modport master (input  bvalid, bid, bresp, output bready);
  modport slave  (output bvalid, bid, bresp, input  bready);
endinterface

interface AXI4_R_IF #(
  parameter int ID_WIDTH   = 6,
  parameter int DATA_WIDTH = 256
);
  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (input  rvalid, rid, rdata, rresp, rlast, output rready);
  modport slave  (output rvalid, rid, rdata, rresp, rlast, input  rready);
endinterface

// File: rtl/pcie_axi_mem_array.sv
// rtl/pcie_axi_mem_array.sv - byte-enabled simple dual-port RAM, one write port, one registered read port
module pcie_axi_mem_array #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH_LG2  = 10
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [DEPTH_LG2-1:0]    waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    re_i,
  input  logic [DEPTH_LG2-1:0]    raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [0:(2**DEPTH_LG2)-1];

  // Read-before-write: a same-word read in the write cycle returns the old word.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (we_i && wstrb_i[b]) begin
        mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/pcie_axi_mem_responder.sv
// rtl/pcie_axi_mem_responder.sv - AXI4 slave that services write/read bursts from on-chip RAM
// Optional random back-pressure when PCIE_AXI_MEM_RAND_STALL_EN is defined.
module pcie_axi_mem_responder
  import pcie_axi_mem_responder_pkg::*;
#(
  parameter int ID_WIDTH      = 6,
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 256,
  parameter int MEM_DEPTH_LG2 = 10
) (
  input logic     clk,
  input logic     rst_n,
  AXI4_A_IF.slave aw_if,
  AXI4_W_IF.slave w_if,
  AXI4_B_IF.slave b_if,
  AXI4_A_IF.slave ar_if,
  AXI4_R_IF.slave r_if
);

  localparam int                       STRB_WIDTH = DATA_WIDTH / 8;
  localparam int                       OFF        = $clog2(STRB_WIDTH);
  localparam int                       IDX_HI     = MEM_DEPTH_LG2 + OFF - 1;
  localparam logic [2:0]               FULL_SIZE  = 3'(OFF);
  localparam logic [MEM_DEPTH_LG2-1:0] IDX_ONE    = 1;

  logic stall;
  logic up_q;

  wr_state_t               wr_q, wr_d;
  logic [ID_WIDTH-1:0]     w_id_q, w_id_d;
  logic [MEM_DEPTH_LG2-1:0] w_idx_q, w_idx_d;
  logic [7:0]              w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic                    w_past_q, w_past_d, w_legal_q, w_legal_d, w_err_q, w_err_d;
  logic                    w_at_len, aw_ready, w_ready, b_valid, mem_we;

  rd_state_t               rd_q, rd_d;
  logic [ID_WIDTH-1:0]     r_id_q, r_id_d;
  logic [MEM_DEPTH_LG2-1:0] r_idx_q, r_idx_d, ar_idx, mem_raddr;
  logic [7:0]              r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic                    r_legal_q, r_legal_d, r_ok_q, r_ok_d;
  logic                    r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic                    ar_ready, mem_re;
  logic [DATA_WIDTH-1:0]   mem_rdata;

`ifdef PCIE_AXI_MEM_RAND_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign w_at_len = !w_past_q && (w_beat_q == w_len_q);
  assign ar_idx   = ar_if.aaddr[IDX_HI:OFF];

  always_comb begin
    wr_d = wr_q; w_id_d = w_id_q; w_idx_d = w_idx_q; w_len_d = w_len_q; w_beat_d = w_beat_q;
    w_past_d = w_past_q; w_legal_d = w_legal_q; w_err_d = w_err_q;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; mem_we = 1'b0;
    unique case (wr_q)
      W_IDLE: begin
        aw_ready = up_q;
        if (aw_if.avalid && up_q) begin
          wr_d      = W_DATA;
          w_id_d    = aw_if.aid;
          w_idx_d   = aw_if.aaddr[IDX_HI:OFF];
          w_len_d   = aw_if.alen;
          w_beat_d  = 8'd0;
          w_past_d  = 1'b0;
          w_err_d   = 1'b0;
          w_legal_d = (aw_if.aburst == INCR) && (aw_if.asize == FULL_SIZE);
        end
      end
      W_DATA: begin
        w_ready = !stall;
        if (w_if.wvalid && !stall) begin
          mem_we   = w_legal_q && !w_past_q;
          w_idx_d  = w_idx_q + IDX_ONE;
          w_beat_d = w_beat_q + 8'd1;
          if (w_at_len) w_past_d = 1'b1;
          // Early wlast and missing wlast both flag the burst as malformed.
          if (w_if.wlast != w_at_len) w_err_d = 1'b1;
          if (w_if.wlast) wr_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (b_if.bready) wr_d = W_IDLE;
      end
      default: wr_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_d = rd_q; r_id_d = r_id_q; r_idx_d = r_idx_q; r_len_d = r_len_q; r_beat_d = r_beat_q;
    r_legal_d = r_legal_q; r_ok_d = r_ok_q; r_valid_d = r_valid_q; r_last_d = r_last_q;
    ar_ready = 1'b0; mem_re = 1'b0; mem_raddr = r_idx_q;
    unique case (rd_q)
      R_IDLE: begin
        ar_ready = up_q;
        if (ar_if.avalid && up_q) begin
          rd_d      = R_DATA;
          mem_re    = 1'b1;
          mem_raddr = ar_idx;
          r_idx_d   = ar_idx + IDX_ONE;
          r_id_d    = ar_if.aid;
          r_len_d   = ar_if.alen;
          r_beat_d  = 8'd0;
          r_legal_d = (ar_if.aburst == INCR) && (ar_if.asize == FULL_SIZE);
          r_ok_d    = r_legal_d;
          r_valid_d = 1'b1;
          r_last_d  = (ar_if.alen == 8'd0);
        end
      end
      R_DATA: begin
        if (r_valid_q && r_if.rready && r_last_q) begin
          rd_d      = R_IDLE;
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
        end else if ((!r_valid_q || r_if.rready) && !stall) begin
          // Next word is fetched in the accepting cycle so beats stream back to back.
          mem_re    = 1'b1;
          r_idx_d   = r_idx_q + IDX_ONE;
          r_beat_d  = r_beat_q + 8'd1;
          r_valid_d = 1'b1;
          r_last_d  = ((r_beat_q + 8'd1) == r_len_q);
        end else if (r_valid_q && r_if.rready) begin
          r_valid_d = 1'b0;
        end
      end
      default: rd_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q <= 1'b0;
      wr_q <= W_IDLE; w_id_q <= '0; w_idx_q <= '0; w_len_q <= '0; w_beat_q <= '0;
      w_past_q <= 1'b0; w_legal_q <= 1'b1; w_err_q <= 1'b0;
      rd_q <= R_IDLE; r_id_q <= '0; r_idx_q <= '0; r_len_q <= '0; r_beat_q <= '0;
      r_legal_q <= 1'b1; r_ok_q <= 1'b0; r_valid_q <= 1'b0; r_last_q <= 1'b0;
    end else begin
      up_q <= 1'b1;
      wr_q <= wr_d; w_id_q <= w_id_d; w_idx_q <= w_idx_d; w_len_q <= w_len_d; w_beat_q <= w_beat_d;
      w_past_q <= w_past_d; w_legal_q <= w_legal_d; w_err_q <= w_err_d;
      rd_q <= rd_d; r_id_q <= r_id_d; r_idx_q <= r_idx_d; r_len_q <= r_len_d; r_beat_q <= r_beat_d;
      r_legal_q <= r_legal_d; r_ok_q <= r_ok_d; r_valid_q <= r_valid_d; r_last_q <= r_last_d;
    end
  end

  pcie_axi_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LG2  (MEM_DEPTH_LG2)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (w_idx_q),
    .wdata_i (w_if.wdata),
    .wstrb_i (w_if.wstrb),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign aw_if.aready = aw_ready;
  assign w_if.wready  = w_ready;
  assign b_if.bvalid  = b_valid;
  assign b_if.bid     = w_id_q;
  assign b_if.bresp   = (w_legal_q && !w_err_q) ? OKAY : SLVERR;
  assign ar_if.aready = ar_ready;
  assign r_if.rvalid  = r_valid_q;
  assign r_if.rlast   = r_last_q;
  assign r_if.rid     = r_id_q;
  assign r_if.rresp   = r_legal_q ? OKAY : SLVERR;
  // Before any legal fetch and for illegal bursts the RAM word is masked to zero.
  assign r_if.rdata   = r_ok_q ? mem_rdata : '0;

  logic unused_sig;
  assign unused_sig = ^{aw_if.aaddr[ADDR_WIDTH-1:IDX_HI+1], aw_if.aaddr[OFF-1:0], aw_if.acache,
                        aw_if.aprot, aw_if.aqos, aw_if.aregion,
                        ar_if.aaddr[ADDR_WIDTH-1:IDX_HI+1], ar_if.aaddr[OFF-1:0], ar_if.acache,
                        ar_if.aprot, ar_if.aqos, ar_if.aregion};

endmodule

// File: tb/tb_pcie_axi_mem_responder.sv
// tb/tb_pcie_axi_mem_responder.sv - directed self-checking bench for pcie_axi_mem_responder
module tb_pcie_axi_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  AXI4_A_IF #(.ID_WIDTH(6), .ADDR_WIDTH(64)) aw_i ();
  AXI4_W_IF #(.DATA_WIDTH(256))              w_i ();
  AXI4_B_IF #(.ID_WIDTH(6))                  b_i ();
  AXI4_A_IF #(.ID_WIDTH(6), .ADDR_WIDTH(64)) ar_i ();
  AXI4_R_IF #(.ID_WIDTH(6), .DATA_WIDTH(256)) r_i ();

  pcie_axi_mem_responder #(
    .ID_WIDTH(6), .ADDR_WIDTH(64), .DATA_WIDTH(256), .MEM_DEPTH_LG2(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_if(aw_i), .w_if(w_i), .b_if(b_i), .ar_if(ar_i), .r_if(r_i)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $display("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [5:0] id, input logic [255:0] base, input logic [31:0] strb,
                          input int last_beat, output logic [1:0] resp, output logic [5:0] bid,
                          output int hs_cyc);
    int g;
    aw_i.avalid = 1'b1; aw_i.aid = id; aw_i.aaddr = addr; aw_i.alen = len;
    aw_i.asize = 3'd5; aw_i.aburst = burst;
    g = 0;
    while (aw_i.aready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) timeout("aw_handshake");
    hs_cyc = cyc;
    @(negedge clk);
    aw_i.avalid = 1'b0;
    for (int i = 0; i <= last_beat; i++) begin
      w_i.wvalid = 1'b1; w_i.wdata = base + 256'(i); w_i.wstrb = strb; w_i.wlast = (i == last_beat);
      g = 0;
      while (w_i.wready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) timeout("w_handshake");
      @(negedge clk);
    end
    w_i.wvalid = 1'b0; w_i.wlast = 1'b0;
    b_i.bready = 1'b1;
    g = 0;
    while (b_i.bvalid !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) timeout("b_handshake");
    resp = b_i.bresp; bid = b_i.bid;
    @(negedge clk);
    b_i.bready = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [5:0] id, input bit toggle,
                         output logic [255:0] data [16], output logic last [16], output int nb,
                         output logic [1:0] resp, output logic [5:0] rid, output int hs_cyc);
    int g;
    logic [255:0] hd;
    logic hl, rr;
    bit pend;
    ar_i.avalid = 1'b1; ar_i.aid = id; ar_i.aaddr = addr; ar_i.alen = len;
    ar_i.asize = size; ar_i.aburst = 2'b01;
    g = 0;
    while (ar_i.aready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) timeout("ar_handshake");
    hs_cyc = cyc;
    @(negedge clk);
    ar_i.avalid = 1'b0;
    nb = 0; pend = 0; rr = 1'b0; g = 0; resp = 2'bxx; rid = 'x;
    while (nb <= int'(len) && g < 200) begin
      if (pend) begin
        check("stall_rvalid", r_i.rvalid, 1'b1);
        check("stall_rdata", r_i.rdata, hd);
        check("stall_rlast", r_i.rlast, hl);
        pend = 0;
      end
      rr = toggle ? ~rr : 1'b1;
      r_i.rready = rr;
      if (r_i.rvalid === 1'b1) begin
        if (rr) begin
          if (nb < 16) begin data[nb] = r_i.rdata; last[nb] = r_i.rlast; end
          resp = r_i.rresp; rid = r_i.rid;
          nb++;
        end else begin
          hd = r_i.rdata; hl = r_i.rlast; pend = 1;
        end
      end
      @(negedge clk);
      g++;
    end
    r_i.rready = 1'b0;
    if (g >= 200) timeout("r_beats");
    check("rvalid_after_last", r_i.rvalid, 1'b0);
  endtask

  logic [255:0] rd_data [16];
  logic         rd_last [16];
  logic [255:0] rd2_data [16];
  logic         rd2_last [16];
  logic [255:0] newv;
  logic [1:0]   resp, resp2;
  logic [5:0]   id, id2;
  int           nb, nb2, hsc, hsc2;

  initial begin
    aw_i.avalid = 0; aw_i.aid = 0; aw_i.aaddr = 0; aw_i.alen = 0; aw_i.asize = 0; aw_i.aburst = 0;
    aw_i.acache = 0; aw_i.aprot = 0; aw_i.aqos = 0; aw_i.aregion = 0;
    ar_i.avalid = 0; ar_i.aid = 0; ar_i.aaddr = 0; ar_i.alen = 0; ar_i.asize = 0; ar_i.aburst = 0;
    ar_i.acache = 0; ar_i.aprot = 0; ar_i.aqos = 0; ar_i.aregion = 0;
    w_i.wvalid = 0; w_i.wdata = 0; w_i.wstrb = 0; w_i.wlast = 0;
    b_i.bready = 0; r_i.rready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", aw_i.aready, 1'b0);
    check("rst_arready", ar_i.aready, 1'b0);
    check("rst_wready", w_i.wready, 1'b0);
    check("rst_bvalid", b_i.bvalid, 1'b0);
    check("rst_rvalid", r_i.rvalid, 1'b0);
    check("rst_rlast", r_i.rlast, 1'b0);
    check("rst_bid_bresp", {b_i.bid, b_i.bresp}, 8'h00);
    check("rst_rid_rresp", {r_i.rid, r_i.rresp}, 8'h00);
    check("rst_rdata", r_i.rdata, 256'h0);
    rst_n = 1'b1;
    #1;
    check("rel_awready_before_edge", aw_i.aready, 1'b0);
    @(negedge clk);
    check("rel_awready", aw_i.aready, 1'b1);
    check("rel_arready", ar_i.aready, 1'b1);

    // Basic 4-beat write and readback at 0x40
    do_write(64'h40, 8'd3, 2'b01, 6'd5, 256'h1, 32'hFFFF_FFFF, 3, resp, id, hsc);
    check("wr1_bresp", resp, 2'b00);
    check("wr1_bid", id, 6'd5);
    do_read(64'h40, 8'd3, 3'd5, 6'd9, 1'b0, rd_data, rd_last, nb, resp, id, hsc);
    check("rd1_beats", nb, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd1_data%0d", i), rd_data[i], 256'(i + 1));
      check($sformatf("rd1_last%0d", i), rd_last[i], (i == 3));
    end
    check("rd1_rresp", resp, 2'b00);
    check("rd1_rid", id, 6'd9);

    // Partial strobe over an all-ones word
    do_write(64'h200, 8'd0, 2'b01, 6'd1, {256{1'b1}}, 32'hFFFF_FFFF, 0, resp, id, hsc);
    newv = {8{32'h1234_5678}};
    do_write(64'h200, 8'd0, 2'b01, 6'd2, newv, 32'h0000_FFFF, 0, resp, id, hsc);
    check("strb_bresp", resp, 2'b00);
    do_read(64'h200, 8'd0, 3'd5, 6'd3, 1'b0, rd_data, rd_last, nb, resp, id, hsc);
    check("strb_data", rd_data[0], {{128{1'b1}}, 128'h1234_5678_1234_5678_1234_5678_1234_5678});

    // 8-beat read with rready toggling every cycle
    do_write(64'h400, 8'd7, 2'b01, 6'd4, 256'h100, 32'hFFFF_FFFF, 7, resp, id, hsc);
    check("wr8_bresp", resp, 2'b00);
    do_read(64'h400, 8'd7, 3'd5, 6'd6, 1'b1, rd_data, rd_last, nb, resp, id, hsc);
    check("tog_beats", nb, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tog_data%0d", i), rd_data[i], 256'h100 + 256'(i));
      check($sformatf("tog_last%0d", i), rd_last[i], (i == 7));
    end

    // Illegal WRAP write leaves RAM untouched; illegal size read returns zero
    do_write(64'h40, 8'd1, 2'b10, 6'd7, 256'hAA, 32'hFFFF_FFFF, 1, resp, id, hsc);
    check("wrap_bresp", resp, 2'b10);
    check("wrap_bid", id, 6'd7);
    do_read(64'h40, 8'd1, 3'd5, 6'd8, 1'b0, rd_data, rd_last, nb, resp, id, hsc);
    check("wrap_ram0", rd_data[0], 256'h1);
    check("wrap_ram1", rd_data[1], 256'h2);
    do_read(64'h40, 8'd0, 3'd3, 6'd10, 1'b0, rd_data, rd_last, nb, resp, id, hsc);
    check("size_rresp", resp, 2'b10);
    check("size_rdata", rd_data[0], 256'h0);
    check("size_rlast", rd_last[0], 1'b1);

    // Early wlast on the second beat of a 4-beat burst
    do_write(64'h600, 8'd3, 2'b01, 6'd11, 256'h300, 32'hFFFF_FFFF, 1, resp, id, hsc);
    check("early_bresp", resp, 2'b10);
    check("early_bid", id, 6'd11);
    check("early_awready", aw_i.aready, 1'b1);

    // AW and AR offered together
    @(negedge clk);
    check("dual_awready", aw_i.aready, 1'b1);
    check("dual_arready", ar_i.aready, 1'b1);
    fork
      do_write(64'h800, 8'd1, 2'b01, 6'd12, 256'h500, 32'hFFFF_FFFF, 1, resp, id, hsc);
      do_read(64'h400, 8'd1, 3'd5, 6'd13, 1'b0, rd2_data, rd2_last, nb2, resp2, id2, hsc2);
    join
    check("dual_same_cycle", hsc2, hsc);
    check("dual_bresp", resp, 2'b00);
    check("dual_rd0", rd2_data[0], 256'h100);
    check("dual_rd1", rd2_data[1], 256'h101);
    check("dual_rid", id2, 6'd13);
    do_read(64'h800, 8'd1, 3'd5, 6'd14, 1'b0, rd_data, rd_last, nb, resp, id, hsc);
    check("dual_wr0", rd_data[0], 256'h500);
    check("dual_wr1", rd_data[1], 256'h501);

    // Reset in the middle of a read burst
    @(negedge clk);
    ar_i.avalid = 1'b1; ar_i.aid = 6'd3; ar_i.aaddr = 64'h400; ar_i.alen = 8'd7;
    ar_i.asize = 3'd5; ar_i.aburst = 2'b01;
    @(negedge clk);
    ar_i.avalid = 1'b0;
    check("mid_rvalid_pre", r_i.rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rvalid_rst", r_i.rvalid, 1'b0);
    check("mid_rlast_rst", r_i.rlast, 1'b0);
    check("mid_arready_rst", ar_i.aready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(64'h400, 8'd0, 3'd5, 6'd15, 1'b0, rd_data, rd_last, nb, resp, id, hsc);
    check("post_rst_data", rd_data[0], 256'h100);
    check("post_rst_rresp", resp, 2'b00);
    check("post_rst_rid", id, 6'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/pcie_axi_mem_responder.md
Name: pcie_axi_mem_responder

Overview:
AXI4 slave memory responder that terminates the PCIe core's outbound AXI master port (aw/ar/w/r/b _if_master side of PCIE_TOP).
Accepts inbound-TLP-generated write and read bursts and services them from an on-chip byte-enabled RAM.
Used as the host-memory/BAR target in system simulation and as a synthesizable scratch BAR in FPGA builds.
Write and read paths are independent; each path has one burst outstanding.

Parameters:
ID_WIDTH, 6, AXI ID width
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 256, data bus width; STRB_WIDTH = DATA_WIDTH/8
MEM_DEPTH_LG2, 10, log2 of RAM depth in DATA_WIDTH words

Ports:
clk  input  1  single clock
rst_n  input  1  reset, asynchronous, active-low
aw_if  AXI4_A_IF slave modport  ID/ADDR params  write address channel
w_if  AXI4_W_IF slave modport  DATA/STRB params  write data channel
b_if  AXI4_B_IF slave modport  ID param  write response channel
ar_if  AXI4_A_IF slave modport  ID/ADDR params  read address channel
r_if  AXI4_R_IF slave modport  ID/DATA params  read data channel

Behaviour:
- Reset (rst_n low, async): aready, wready, bvalid, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0; both FSMs to IDLE. Readies rise on first clk edge after rst_n deasserts. Reset mid-burst abandons the burst; RAM contents are not cleared.
- Word index = aaddr[MEM_DEPTH_LG2+log2(STRB_WIDTH)-1 : log2(STRB_WIDTH)]; upper address bits ignored (aliasing); index increments by 1 per beat, wraps modulo 2^MEM_DEPTH_LG2.
- Burst is legal iff aburst==INCR and asize==log2(STRB_WIDTH). Illegal bursts complete normally on the bus with SLVERR; no RAM write occurs, and read data is 0.
- cache/prot/qos/region are ignored.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: aready=1. On avalid&aready, latch id, index, alen, and legal flag; go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes the bytes enabled by wstrb (if legal) and increments the beat counter.
  - W_DATA error cases: wlast before beat alen, or beat alen without wlast, sets the error flag. Beats beyond alen are consumed but not written.
  - W_DATA exit: the burst ends on the wlast beat; go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY, or SLVERR if illegal or error. Hold until bready; then W_IDLE, with aready=1 the next cycle.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: aready=1. On handshake, rdata register loads mem[index]; rvalid=1 the next cycle.
  - R_DATA: on rvalid&rready, load the next word the same cycle (zero-bubble throughput). rlast=1 on beat alen. rid=latched id; rresp=OKAY or SLVERR.
  - Stall: rvalid, rdata, rlast, rid and rresp hold stable while rready=0.
  - Exit: after the last handshake, rvalid=0 and go to R_IDLE.
- Simultaneous read and write to the same word in one cycle: the read returns old data.
- AW and AR may be accepted in the same cycle.
- RAM is inferred, 1 write port + 1 read port, with registered read.

Optional Feature:
PCIE_AXI_MEM_RAND_STALL_EN
- Defined: 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; steps every cycle).
  - When lfsr[0]=1: wready is forced 0 in W_DATA, and the next read beat is not launched. An already-asserted rvalid is never dropped.
  - Bursts still complete with identical data and responses.
- Undefined: no LFSR; timing exactly as above.

Decomposition:
- PCIE_PKG gains:
  - AXI resp constants: OKAY=2'b00, SLVERR=2'b10.
  - Burst constant INCR=2'b01.
  - Enums wr_state_t {W_IDLE, W_DATA, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
- One sub-module: pcie_axi_mem_array, a parameterized byte-enable simple dual-port RAM with registered read.

Test Plan:
- AW addr 0x40, len 3, INCR, size 5; 4 beats of data 'h1..'h4, strb all-ones -> bresp OKAY with the matching bid. AR same addr/len -> 4 beats 'h1..'h4, rlast on beat 4, rresp OKAY.
- Write strb 32'h0000_FFFF over a word holding all-F -> readback has the lower 16 bytes new and the upper 16 bytes F.
- Read len 7 with rready toggling 1/0 every cycle -> rdata and rlast stable across stalls; 8 beats in order.
- AW aburst=WRAP, len 1 -> both beats accepted, bresp SLVERR, RAM unchanged; AR asize=3 -> rresp SLVERR, rdata 0.
- AW len 3 with wlast on beat 2 -> burst ends; bresp SLVERR.
- AW and AR asserted in the same cycle to different addresses -> both aready handshakes happen in that cycle; both bursts complete correctly. Reset asserted mid-read -> rvalid=0 immediately; the next read succeeds.
